// File: rtl/pipe_dec_pkg.sv
// pipe_dec_pkg: shared constants for the pipe_decoder slice.
//   - opcode encodings NOP..JEQ (3-bit, zero-extended by users)
//   - control-word bit indices and the control value of every opcode
//   - reads_rs1 / reads_rs2: which source fields an opcode consumes
package pipe_dec_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MOVI = 3'd3;
  localparam logic [2:0] OP_LODR = 3'd4;
  localparam logic [2:0] OP_STOR = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_JEQ  = 3'd7;

  localparam int unsigned CTRL_MEMREAD  = 7;
  localparam int unsigned CTRL_MEMWRITE = 6;
  localparam int unsigned CTRL_RESMEM   = 5;
  localparam int unsigned CTRL_JEQ      = 4;
  localparam int unsigned CTRL_JMP      = 3;
  localparam int unsigned CTRL_ALUOP    = 2;
  localparam int unsigned CTRL_RESIMM   = 1;
  localparam int unsigned CTRL_REGWRITE = 0;

  localparam logic [7:0] NOP_CTRL  = 8'h02;
  localparam logic [7:0] ADD_CTRL  = 8'h23;
  localparam logic [7:0] SUB_CTRL  = 8'h27;
  localparam logic [7:0] MOVI_CTRL = 8'h21;
  localparam logic [7:0] LODR_CTRL = 8'h83;
  localparam logic [7:0] STOR_CTRL = 8'h42;
  localparam logic [7:0] JMP_CTRL  = 8'h2A;
  localparam logic [7:0] JEQ_CTRL  = 8'h36;

  function automatic logic reads_rs1(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STOR) ||
           (op == OP_JEQ) || (op == OP_LODR);
  endfunction

  function automatic logic reads_rs2(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STOR) ||
           (op == OP_JEQ);
  endfunction

endpackage

// File: rtl/pipe_decoder_dec_ctrl_rom.sv
// dec_ctrl_rom: combinational opcode -> control-word lookup.
//   opcode_i  [OPC_W] opcode
//   ctrl_o    [8]     control word (NOP_CTRL for undefined opcodes)
//   illegal_o [1]     opcode lies outside 0..7
module dec_ctrl_rom
  import pipe_dec_pkg::*;
#(
  parameter int unsigned OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic [7:0]       ctrl_o,
  output logic             illegal_o
);

  always_comb begin
    ctrl_o    = NOP_CTRL;
    illegal_o = (opcode_i >> 3) != '0;
    if (!illegal_o) begin
      case (opcode_i[2:0])
        OP_NOP:  ctrl_o = NOP_CTRL;
        OP_ADD:  ctrl_o = ADD_CTRL;
        OP_SUB:  ctrl_o = SUB_CTRL;
        OP_MOVI: ctrl_o = MOVI_CTRL;
        OP_LODR: ctrl_o = LODR_CTRL;
        OP_STOR: ctrl_o = STOR_CTRL;
        OP_JMP:  ctrl_o = JMP_CTRL;
        OP_JEQ:  ctrl_o = JEQ_CTRL;
        default: ctrl_o = NOP_CTRL;
      endcase
    end
  end

endmodule

// File: rtl/pipe_decoder.sv
// pipe_decoder: registered valid/ready decode stage between fetch and execute.
// Decodes opcode + register fields to the 8-bit control word, inserts one
// bubble on a load-use hazard, supports flush and counts inserted bubbles.
// Ports:
//   clk, rst_n (async, active-low)
//   in_valid/in_ready, in_opcode, in_rd, in_rs1, in_rs2 : upstream side
//   flush                                                : drop stage contents
//   out_valid/out_ready, out_ctrl, out_opcode, out_rd,
//   out_rs1, out_rs2, out_bubble                         : downstream side
//   stall_cnt   : saturating count of bubbles inserted
//   out_illegal : illegal-opcode flag
// Build option: define PIPE_DEC_ILLEGAL_TRAP_EN to drive out_illegal for
// opcodes above 7; otherwise out_illegal is constant 0.
module pipe_decoder
  import pipe_dec_pkg::*;
#(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_ctrl,
  output logic [OPC_W-1:0] out_opcode,
  output logic [REG_W-1:0] out_rd,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic             out_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             out_illegal
);

  logic [7:0] rom_ctrl;
  logic       rom_illegal;

  dec_ctrl_rom #(.OPC_W(OPC_W)) u_rom (
    .opcode_i  (in_opcode),
    .ctrl_o    (rom_ctrl),
    .illegal_o (rom_illegal)
  );

  logic             valid_q,  valid_d;
  logic             bubble_q, bubble_d;
  logic [7:0]       ctrl_q,   ctrl_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic [REG_W-1:0] rd_q,     rd_d;
  logic [REG_W-1:0] rs1_q,    rs1_d;
  logic [REG_W-1:0] rs2_q,    rs2_d;
  logic [CNT_W-1:0] stall_q,  stall_d;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
  logic             ill_q,    ill_d;
`endif

  logic advance, hazard, uses_rd;

  // Illegal opcodes decode as NOP and therefore read no sources, even though
  // their low three bits may alias a real opcode.
  always_comb begin
    uses_rd = !rom_illegal &&
              ((reads_rs1(in_opcode[2:0]) && (in_rs1 == rd_q)) ||
               (reads_rs2(in_opcode[2:0]) && (in_rs2 == rd_q)));
  end

  assign advance  = !valid_q || out_ready;
  assign hazard   = in_valid && valid_q && !bubble_q &&
                    (opcode_q == OPC_W'(OP_LODR)) && uses_rd;
  assign in_ready = advance && !hazard && !flush;

  always_comb begin
    valid_d  = valid_q;
    bubble_d = bubble_q;
    ctrl_d   = ctrl_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    stall_d  = stall_q;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
    ill_d    = ill_q;
`endif
    if (flush) begin
      valid_d  = 1'b0;
      bubble_d = 1'b0;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
      ill_d    = 1'b0;
`endif
    end else if (!advance) begin
      // back-pressure: everything holds
    end else if (hazard) begin
      valid_d  = 1'b1;
      bubble_d = 1'b1;
      ctrl_d   = NOP_CTRL;
      opcode_d = '0;
      rd_d     = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
      ill_d    = 1'b0;
`endif
    end else if (in_valid) begin
      valid_d  = 1'b1;
      bubble_d = 1'b0;
      ctrl_d   = rom_ctrl;
      opcode_d = in_opcode;
      rd_d     = in_rd;
      rs1_d    = in_rs1;
      rs2_d    = in_rs2;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
      ill_d    = rom_illegal;
`endif
    end else begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bubble_q <= 1'b0;
      ctrl_q   <= NOP_CTRL;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      stall_q  <= '0;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
      ill_q    <= 1'b0;
`endif
    end else begin
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
      ctrl_q   <= ctrl_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      stall_q  <= stall_d;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
      ill_q    <= ill_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign out_bubble = bubble_q;
  assign out_ctrl   = ctrl_q;
  assign out_opcode = opcode_q;
  assign out_rd     = rd_q;
  assign out_rs1    = rs1_q;
  assign out_rs2    = rs2_q;
  assign stall_cnt  = stall_q;
`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
  assign out_illegal = ill_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_decoder.sv
// Testbench for pipe_decoder: expected transactions are queued as they are
// issued; a negedge monitor pops and compares on every downstream transfer.
module tb_pipe_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_opcode;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_ctrl;
  logic [4:0] out_opcode;
  logic [2:0] out_rd, out_rs1, out_rs2;
  logic       out_bubble;
  logic [15:0] stall_cnt;
  logic       out_illegal;

  int checks   = 0;
  int failures = 0;

`ifdef PIPE_DEC_ILLEGAL_TRAP_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] ctrl;
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       bub;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_decoder #(.OPC_W(5), .REG_W(3), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_bubble  (out_bubble),
    .stall_cnt   (stall_cnt),
    .out_illegal (out_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2);
    in_valid  = v;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic push(input logic [7:0] c, input logic [4:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2, input logic bub,
                      input logic ill);
    exp_t e;
    e.ctrl = c; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.bub = bub; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the posedge following a negedge where
  // out_valid & out_ready hold (inputs only change just after posedges).
  initial begin
    exp_t act, e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        act = '{ctrl: out_ctrl, op: out_opcode, rd: out_rd, rs1: out_rs1,
                 rs2: out_rs2, bub: out_bubble, ill: out_illegal};
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual=ctrl %0h op %0h bub %0b required=no transfer",
                   act.ctrl, act.op, act.bub);
        end else begin
          e = sb.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL sb_xfer actual=ctrl %0h op %0h rd %0d rs1 %0d rs2 %0d bub %0b ill %0b required=ctrl %0h op %0h rd %0d rs1 %0d rs2 %0d bub %0b ill %0b",
                     act.ctrl, act.op, act.rd, act.rs1, act.rs2, act.bub, act.ill,
                     e.ctrl, e.op, e.rd, e.rs1, e.rs2, e.bub, e.ill);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_ctrl",    32'(out_ctrl), 32'h02);
    chk("rst_stall",   32'(stall_cnt), 32'h0);
    chk("rst_bubble",  32'(out_bubble), 32'h0);
    chk("rst_illegal", 32'(out_illegal), 32'h0);
    chk("rst_opcode",  32'(out_opcode), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // ADD: one-cycle latency
    drive(1'b1, 5'd1, 3'd2, 3'd1, 3'd3); push(8'h23, 5'd1, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0);
    tick();
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_ctrl",  32'(out_ctrl), 32'h23);
    chk("add_rd",    32'(out_rd), 32'h2);
    chk("add_bub",   32'(out_bubble), 32'h0);
    idle(); tick();

    // LODR r3 then SUB using r3 on rs2: exactly one bubble
    drive(1'b1, 5'd4, 3'd3, 3'd1, 3'd0); push(8'h83, 5'd4, 3'd3, 3'd1, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 3'd4, 3'd5, 3'd3);
    push(8'h02, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    push(8'h27, 5'd2, 3'd4, 3'd5, 3'd3, 1'b0, 1'b0);
    #1;
    chk("lu_in_ready_hz", 32'(in_ready), 32'h0);
    chk("lu_hold_lodr",   32'(out_ctrl), 32'h83);
    tick();
    chk("lu_bub",       32'(out_bubble), 32'h1);
    chk("lu_bub_ctrl",  32'(out_ctrl), 32'h02);
    chk("lu_stall1",    32'(stall_cnt), 32'h1);
    chk("lu_in_ready",  32'(in_ready), 32'h1);
    tick();
    chk("lu_sub_ctrl",  32'(out_ctrl), 32'h27);
    chk("lu_sub_bub",   32'(out_bubble), 32'h0);
    idle(); tick();

    // LODR r3 then MOVI (reads no sources): no bubble
    drive(1'b1, 5'd4, 3'd3, 3'd1, 3'd0); push(8'h83, 5'd4, 3'd3, 3'd1, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 3'd5, 3'd3, 3'd3); push(8'h21, 5'd3, 3'd5, 3'd3, 3'd3, 1'b0, 1'b0);
    #1;
    chk("movi_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("movi_ctrl",  32'(out_ctrl), 32'h21);
    chk("movi_stall", 32'(stall_cnt), 32'h1);
    idle(); tick();

    // LODR r6 then LODR with r6 only on rs2 (LODR ignores rs2): no bubble
    drive(1'b1, 5'd4, 3'd6, 3'd0, 3'd0); push(8'h83, 5'd4, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 3'd1, 3'd0, 3'd6); push(8'h83, 5'd4, 3'd1, 3'd0, 3'd6, 1'b0, 1'b0);
    #1;
    chk("ll_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("ll_rd",  32'(out_rd), 32'h1);
    chk("ll_bub", 32'(out_bubble), 32'h0);
    idle(); tick();

    // JEQ held under back-pressure for 5 cycles
    drive(1'b1, 5'd7, 3'd0, 3'd1, 3'd2); push(8'h36, 5'd7, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 3'd7, 3'd2, 3'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",    32'(out_valid), 32'h1);
      chk("bp_ctrl",     32'(out_ctrl), 32'h36);
      chk("bp_rs2",      32'(out_rs2), 32'h2);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    push(8'h23, 5'd1, 3'd7, 3'd2, 3'd2, 1'b0, 1'b0);
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_next_ctrl", 32'(out_ctrl), 32'h23);
    idle(); tick();

    // Held LODR keeps the hazard pending; bubble only when it is consumed
    drive(1'b1, 5'd4, 3'd2, 3'd0, 3'd0); push(8'h83, 5'd4, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 3'd3, 3'd2, 3'd0);
    tick(); tick();
    chk("hh_bub",      32'(out_bubble), 32'h0);
    chk("hh_opcode",   32'(out_opcode), 32'h4);
    chk("hh_stall",    32'(stall_cnt), 32'h1);
    chk("hh_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    push(8'h02, 5'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    push(8'h23, 5'd1, 3'd3, 3'd2, 3'd0, 1'b0, 1'b0);
    #1;
    chk("hh_rel_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("hh_bub2",   32'(out_bubble), 32'h1);
    chk("hh_stall2", 32'(stall_cnt), 32'h2);
    tick();
    chk("hh_add_ctrl", 32'(out_ctrl), 32'h23);
    idle(); tick();

    // Flush during a load-use hazard: no bubble, count unchanged
    drive(1'b1, 5'd4, 3'd4, 3'd0, 3'd0); push(8'h83, 5'd4, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 3'd5, 3'd4, 3'd4); flush = 1'b1;
    #1;
    chk("fh_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("fh_valid", 32'(out_valid), 32'h0);
    chk("fh_bub",   32'(out_bubble), 32'h0);
    chk("fh_stall", 32'(stall_cnt), 32'h2);
    flush = 1'b0; idle(); tick();

    // Flush with STOR pending and a new instruction offered
    drive(1'b1, 5'd5, 3'd1, 3'd2, 3'd3); push(8'h42, 5'd5, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 3'd6, 3'd6, 3'd6); flush = 1'b1;
    #1;
    chk("fs_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("fs_valid", 32'(out_valid), 32'h0);
    chk("fs_stall", 32'(stall_cnt), 32'h2);
    flush = 1'b0; idle(); tick();
    chk("fs_dropped", 32'(out_valid), 32'h0);

    // Illegal opcode, then a legal one clears the flag
    drive(1'b1, 5'h1F, 3'd1, 3'd1, 3'd1); push(8'h02, 5'h1F, 3'd1, 3'd1, 3'd1, 1'b0, ILL);
    tick();
    chk("ill_flag", 32'(out_illegal), 32'(ILL));
    chk("ill_ctrl", 32'(out_ctrl), 32'h02);
    drive(1'b1, 5'd1, 3'd1, 3'd1, 3'd1); push(8'h23, 5'd1, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0);
    tick();
    chk("ill_clear", 32'(out_illegal), 32'h0);
    idle(); tick();

    // Asynchronous reset mid-stream
    drive(1'b1, 5'd1, 3'd2, 3'd3, 3'd4);
    tick();
    chk("ar_valid_pre", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    idle();
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_stall", 32'(stall_cnt), 32'h0);
    chk("ar_ctrl",  32'(out_ctrl), 32'h02);
    chk("ar_rd",    32'(out_rd), 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_post_valid", 32'(out_valid), 32'h0);
    chk("ar_in_ready",   32'(in_ready), 32'h1);
    tick();

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
